sram_pattern_checker: RTL and testbench

Read-side counterpart of the SRAM test pattern sequencer: consumes SRAM read data in ascending address order and compares each word with the expected test pattern. It steps through the fixed seven-pattern sequence over the full address space. It counts mismatches, optionally captures the first failure, and reports done/pass to the test controller. It sits between the SRAM read path and the status LEDs/UART of the sram_test example.

---
 rtl/sram_pattern_checker.sv | 123 ++++++++++++
 tb/tb_sram_pattern_checker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_pattern_checker.sv
// rtl/sram_pattern_checker.sv - checks SRAM read data against the seven-pattern test sequence
// Optional first-mismatch capture: define SRAM_PATTERN_CHECKER_FAIL_CAPTURE_EN.
module sram_pattern_checker #(
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 20,
  parameter int ERR_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] custom,
  input  logic                 rd_valid,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2:0]           pattern_idx,
  output logic [ADDR_BITS-1:0] addr,
  output logic [ERR_BITS-1:0]  error_count,
  output logic [2:0]           fail_pattern,
  output logic [ADDR_BITS-1:0] fail_addr,
  output logic [DATA_BITS-1:0] fail_expected,
  output logic [DATA_BITS-1:0] fail_actual
);

  // state[0] is busy and state[1] is done, so both outputs come straight off flops
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_CHECK = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;
  localparam logic [ERR_BITS-1:0]  ERR_ONE  = 1;

  logic [1:0]           state;
  logic [DATA_BITS-1:0] custom_q;
  logic [DATA_BITS-1:0] expected;
  logic                 beat;
  logic                 mismatch;
  logic                 last_beat;
  logic [ERR_BITS-1:0]  err_next;

  always_comb begin
    expected = '0;
    case (pattern_idx)
      3'd1:    expected = '1;
      3'd2:    expected = {(DATA_BITS/2){2'b10}};
      3'd3:    expected = {(DATA_BITS/2){2'b01}};
      3'd4:    expected = {{(DATA_BITS/2){1'b0}}, {(DATA_BITS/2){1'b1}}};
      3'd6:    expected = custom_q;
      default: expected = '0;
    endcase
  end

  // A start in the same cycle as rd_valid discards that beat
  assign beat      = (state == ST_CHECK) && rd_valid && !start;
  assign mismatch  = beat && (rd_data != expected);
  assign last_beat = (pattern_idx == 3'd6) && (addr == '1);
  assign err_next  = (mismatch && (error_count != '1)) ? error_count + ERR_ONE : error_count;

  assign busy = state[0];
  assign done = state[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pass        <= 1'b0;
      pattern_idx <= '0;
      addr        <= '0;
      error_count <= '0;
      custom_q    <= '0;
    end else if (start) begin
      state       <= ST_CHECK;
      pass        <= 1'b0;
      pattern_idx <= '0;
      addr        <= '0;
      error_count <= '0;
      custom_q    <= custom;
    end else if (beat) begin
      error_count <= err_next;
      addr        <= addr + ADDR_ONE;
      if (addr == '1) begin
        if (last_beat) begin
          state <= ST_DONE;
          pass  <= (err_next == '0);
        end else begin
          pattern_idx <= pattern_idx + 3'd1;
        end
      end
    end
  end

`ifdef SRAM_PATTERN_CHECKER_FAIL_CAPTURE_EN
  logic fail_seen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fail_seen     <= 1'b0;
      fail_pattern  <= '0;
      fail_addr     <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else if (start) begin
      fail_seen     <= 1'b0;
      fail_pattern  <= '0;
      fail_addr     <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else if (mismatch && !fail_seen) begin
      fail_seen     <= 1'b1;
      fail_pattern  <= pattern_idx;
      fail_addr     <= addr;
      fail_expected <= expected;
      fail_actual   <= rd_data;
    end
  end
`else
  assign fail_pattern  = '0;
  assign fail_addr     = '0;
  assign fail_expected = '0;
  assign fail_actual   = '0;
`endif

endmodule

// File: tb/tb_sram_pattern_checker.sv
// tb/tb_sram_pattern_checker.sv - directed and randomized bench for sram_pattern_checker
// Small geometry (4 words, 4-bit error counter) so full sequences and saturation are cheap.
module tb_sram_pattern_checker;

  localparam int DW    = 16;
  localparam int AW    = 2;
  localparam int EW    = 4;
  localparam int WORDS = 1 << AW;
  localparam int BEATS = 7 * WORDS;
  localparam int EMAX  = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] custom;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          pass;
  logic [2:0]    pattern_idx;
  logic [AW-1:0] addr;
  logic [EW-1:0] error_count;
  logic [2:0]    fail_pattern;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_expected;
  logic [DW-1:0] fail_actual;

  sram_pattern_checker #(.DATA_BITS(DW), .ADDR_BITS(AW), .ERR_BITS(EW)) dut (
    .clk(clk), .reset(reset), .start(start), .custom(custom),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done), .pass(pass), .pattern_idx(pattern_idx),
    .addr(addr), .error_count(error_count),
    .fail_pattern(fail_pattern), .fail_addr(fail_addr),
    .fail_expected(fail_expected), .fail_actual(fail_actual)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 idle, 1 checking, 2 done; m_k counts accepted beats
  int          m_state, m_k, m_err;
  logic [DW-1:0] m_custom;
  bit          m_fs;
  int          m_fp, m_fa;
  logic [DW-1:0] m_fe, m_fd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_word(input int p, input logic [DW-1:0] c);
    logic [DW-1:0] w;
    w = '0;
    case (p)
      1: w = '1;
      2: for (int i = 0; i < DW; i++) w[i] = (i % 2 == 1);
      3: for (int i = 0; i < DW; i++) w[i] = (i % 2 == 0);
      4: for (int i = 0; i < DW / 2; i++) w[i] = 1'b1;
      6: w = c;
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [DW-1:0] good_word();
    return exp_word(m_k / WORDS, m_custom);
  endfunction

  task automatic model_clear();
    m_k = 0; m_err = 0; m_fs = 0; m_fp = 0; m_fa = 0; m_fe = '0; m_fd = '0;
  endtask

  task automatic cycle(input bit st, input bit v, input logic [DW-1:0] d, input logic [DW-1:0] c);
    logic [DW-1:0] e;
    @(negedge clk);
    start = st; rd_valid = v; rd_data = d; custom = c;
    @(posedge clk);
    #1;
    start = 1'b0; rd_valid = 1'b0;
    if (st) begin
      model_clear();
      m_state = 1;
      m_custom = c;
    end else if (v && m_state == 1) begin
      e = exp_word(m_k / WORDS, m_custom);
      if (d !== e) begin
        if (m_err < EMAX) m_err++;
        if (!m_fs) begin
          m_fs = 1; m_fp = m_k / WORDS; m_fa = m_k % WORDS; m_fe = e; m_fd = d;
        end
      end
      m_k++;
      if (m_k == BEATS) m_state = 2;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'(m_state == 1));
    check({tag, ".done"}, 32'(done), 32'(m_state == 2));
    check({tag, ".pass"}, 32'(pass), 32'(m_state == 2 && m_err == 0));
    check({tag, ".addr"}, 32'(addr), 32'((m_state == 1) ? (m_k % WORDS) : 0));
    check({tag, ".err"}, 32'(error_count), 32'(m_err));
    if (m_state == 1) check({tag, ".pidx"}, 32'(pattern_idx), 32'(m_k / WORDS));
`ifdef SRAM_PATTERN_CHECKER_FAIL_CAPTURE_EN
    check({tag, ".fpat"}, 32'(fail_pattern), 32'(m_fp));
    check({tag, ".faddr"}, 32'(fail_addr), 32'(m_fa));
    check({tag, ".fexp"}, 32'(fail_expected), 32'(m_fe));
    check({tag, ".fact"}, 32'(fail_actual), 32'(m_fd));
`else
    check({tag, ".fpat"}, 32'(fail_pattern), 32'(0));
    check({tag, ".fdata"}, 32'({fail_addr, fail_expected, fail_actual} != '0), 32'(0));
`endif
  endtask

  task automatic full_good_run(input string tag, input logic [DW-1:0] c);
    cycle(1'b1, 1'b0, '0, c);
    check_model({tag, ".start"});
    while (m_state == 1) begin
      cycle(1'b0, 1'b1, good_word(), c);
      check_model(tag);
    end
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    m_state = 0;
    model_clear();
    check_model(tag);
    @(negedge clk);
    check_model({tag, ".held"});
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rd_valid = 1'b0; rd_data = '0; custom = '0;
    m_state = 0; m_custom = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check_model("reset");
    reset = 1'b0;

    // beats while idle are ignored
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, DW'($urandom), custom);
      check_model("idle");
    end

    // clean run with 0xBEEF custom pattern
    full_good_run("runA", 16'hBEEF);
    check("A.pass", 32'(pass), 32'(1));
    check("A.addr", 32'(addr), 32'(0));

    // single mismatch at pattern 1, address 2
    cycle(1'b1, 1'b0, '0, 16'hBEEF);
    while (m_state == 1) begin
      cycle(1'b0, 1'b1, (m_k == WORDS + 2) ? 16'hFFFE : good_word(), custom);
      check_model("runB");
    end
    check("B.err", 32'(error_count), 32'(1));
    check("B.pass", 32'(pass), 32'(0));
`ifdef SRAM_PATTERN_CHECKER_FAIL_CAPTURE_EN
    check("B.fpat", 32'(fail_pattern), 32'(1));
    check("B.faddr", 32'(fail_addr), 32'(2));
    check("B.fexp", 32'(fail_expected), 32'(16'hFFFF));
    check("B.fact", 32'(fail_actual), 32'(16'hFFFE));
`endif

    // beats while done are ignored
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, DW'($urandom), custom);
      check_model("doneidle");
    end

    // correct data with random gaps
    cycle(1'b1, 1'b0, '0, 16'hBEEF);
    for (int i = 0; i < 400 && m_state == 1; i++) begin
      if ($urandom_range(0, 2) == 0) cycle(1'b0, 1'b0, DW'($urandom), custom);
      else cycle(1'b0, 1'b1, good_word(), custom);
      check_model("gaps");
    end
    check("C.done", 32'(done), 32'(1));
    check("C.pass", 32'(pass), 32'(1));

    // reset during pattern 3, then a fresh clean run
    cycle(1'b1, 1'b0, '0, 16'h1234);
    while (m_k < 3 * WORDS + 1) cycle(1'b0, 1'b1, (m_k == 2) ? 16'h0001 : good_word(), custom);
    check_model("preD");
    async_reset("D.reset");
    full_good_run("runD", DW'($urandom));
    check("D.pass", 32'(pass), 32'(1));

    // every beat wrong: counter saturates
    cycle(1'b1, 1'b0, '0, 16'hA5A5);
    while (m_state == 1) begin
      cycle(1'b0, 1'b1, ~good_word(), custom);
      check_model("allbad");
    end
    check("E.err", 32'(error_count), 32'(EMAX));
    check("E.pass", 32'(pass), 32'(0));

    // restart during pattern 2 after an error; start beats the concurrent rd_valid
    cycle(1'b1, 1'b0, '0, 16'h0F0F);
    while (m_k < 2 * WORDS + 1) cycle(1'b0, 1'b1, (m_k == 1) ? 16'h8000 : good_word(), custom);
    check_model("preF");
    cycle(1'b1, 1'b1, DW'($urandom), 16'hC3C3);
    check("F.err", 32'(error_count), 32'(0));
    check("F.pidx", 32'(pattern_idx), 32'(0));
    check("F.addr", 32'(addr), 32'(0));
    check("F.busy", 32'(busy), 32'(1));
    while (m_state == 1) begin
      cycle(1'b0, 1'b1, good_word(), custom);
      check_model("runF");
    end
    check("F.pass", 32'(pass), 32'(1));

    // random data, errors counted by the model
    for (int r = 0; r < 3; r++) begin
      cycle(1'b1, 1'b0, '0, DW'($urandom));
      for (int i = 0; i < 400 && m_state == 1; i++) begin
        case ($urandom_range(0, 5))
          0: cycle(1'b0, 1'b0, DW'($urandom), custom);
          1: cycle(1'b0, 1'b1, DW'($urandom), custom);
          default: cycle(1'b0, 1'b1, good_word(), custom);
        endcase
        check_model("rand");
      end
      check("G.done", 32'(done), 32'(1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
